rom_download_ctrl: RTL and testbench

//  Sits between hps_io and the Pickin core on the ROM download path. Registers the ioctl byte

---
 rtl/botanic_pkg.sv | 14 +
 rtl/rst_hold_timer.sv | 30 +++
 rtl/rom_download_ctrl.sv | 153 +++++++++++++++
 tb/tb_rom_download_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/botanic_pkg.sv
// Shared types and default ROM map for the Pickin/Botanic ROM download path.
// The default sizes are also used where the core ROMs are instantiated.
package botanic_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} dl_state_t;
  typedef enum logic [1:0] {RGN_CPU = 2'd0, RGN_GFX = 2'd1, RGN_PROM = 2'd2} rgn_t;

  localparam int unsigned DEF_ADDR_W      = 17;
  localparam int unsigned DEF_CPU_BYTES   = 32'h0000_C000;
  localparam int unsigned DEF_GFX_BYTES   = 32'h0000_6000;
  localparam int unsigned DEF_PROM_BYTES  = 32'h0000_0040;
  localparam int unsigned DEF_HOLD_CYCLES = 4096;

endpackage

// File: rtl/rst_hold_timer.sv
// Core-reset stretch timer: counts HOLD_CYCLES cycles while run is high and
// pulses done on the last one; start forces the count back to zero.
module rst_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (start) begin
      hold_cnt <= '0;
    end else if (run && hold_cnt != LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign done = run && !start && (hold_cnt == LAST);

endmodule

// File: rtl/rom_download_ctrl.sv
// ROM download controller: registers the hps_io byte stream, tags regions,
// verifies the byte count and owns the core reset.
module rom_download_ctrl
  import botanic_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned CPU_BYTES   = DEF_CPU_BYTES,
  parameter int unsigned GFX_BYTES   = DEF_GFX_BYTES,
  parameter int unsigned PROM_BYTES  = DEF_PROM_BYTES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              usr_reset,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [1:0]        dn_rgn,
  output logic              core_reset,
  output logic              load_ok,
  output logic              load_err
);

  localparam int unsigned TOTAL = CPU_BYTES + GFX_BYTES + PROM_BYTES;
  localparam int unsigned PROM_BASE_I = CPU_BYTES + GFX_BYTES;
  localparam logic [24:0]     TOTAL_A   = TOTAL[24:0];
  localparam logic [24:0]     GFX_BASE  = CPU_BYTES[24:0];
  localparam logic [24:0]     PROM_BASE = PROM_BASE_I[24:0];
  localparam logic [ADDR_W:0] TOTAL_C   = TOTAL[ADDR_W:0];

  function automatic rgn_t rgn_of(input logic [24:0] a);
    if (a < GFX_BASE)  return RGN_CPU;
    if (a < PROM_BASE) return RGN_GFX;
    return RGN_PROM;
  endfunction

  // The counter sticks at all-ones so a runaway stream can never wrap back to TOTAL.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  dl_state_t         state, state_nxt;
  logic [ADDR_W:0]   byte_cnt, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic              ok_nxt, err_nxt, wr_nxt, core_reset_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic [1:0]        rgn_nxt;
  logic              go_load, timer_start, timer_done;

  rst_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .start (timer_start),
    .run   (state == HOLD),
    .done  (timer_done)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = byte_cnt;
    ovf_nxt     = ovf;
    ok_nxt      = load_ok;
    err_nxt     = load_err;
    wr_nxt      = 1'b0;
    addr_nxt    = dn_addr;
    data_nxt    = dn_data;
    rgn_nxt     = dn_rgn;
    go_load     = 1'b0;
    timer_start = 1'b0;
    unique case (state)
      IDLE: go_load = ioctl_download;
      LOAD: begin
        if (ioctl_wr) begin
          if (ioctl_addr < TOTAL_A) begin
            wr_nxt   = 1'b1;
            addr_nxt = ioctl_addr[ADDR_W-1:0];
            data_nxt = ioctl_dout;
            rgn_nxt  = rgn_of(ioctl_addr);
            cnt_nxt  = sat_inc(byte_cnt);
          end else begin
            ovf_nxt = 1'b1;
          end
        end
        // The size verdict includes a byte strobed on the same cycle the download drops.
        if (!ioctl_download) begin
          if (cnt_nxt == TOTAL_C && !ovf_nxt) begin
            ok_nxt      = 1'b1;
            state_nxt   = HOLD;
            timer_start = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end
        end
      end
      HOLD: begin
        if (ioctl_download)  go_load = 1'b1;
        else if (usr_reset)  timer_start = 1'b1;
        else if (timer_done) state_nxt = RUN;
      end
      RUN: begin
        if (ioctl_download) begin
          go_load = 1'b1;
        end else if (usr_reset) begin
          state_nxt   = HOLD;
          timer_start = 1'b1;
        end
      end
      ERR:     go_load = ioctl_download;
      default: state_nxt = IDLE;
    endcase
    if (go_load) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
    end
    core_reset_nxt = (state_nxt != RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      ovf        <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      core_reset <= 1'b1;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_rgn     <= '0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= cnt_nxt;
      ovf        <= ovf_nxt;
      load_ok    <= ok_nxt;
      load_err   <= err_nxt;
      core_reset <= core_reset_nxt;
      dn_wr      <= wr_nxt;
      dn_addr    <= addr_nxt;
      dn_data    <= data_nxt;
      dn_rgn     <= rgn_nxt;
    end
  end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Scoreboard bench for rom_download_ctrl with a scaled-down ROM map and a short
// reset stretch so that several full downloads fit in a short run.
module tb_rom_download_ctrl;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned CPU_B  = 32'h0C0;
  localparam int unsigned GFX_B  = 32'h060;
  localparam int unsigned PROM_B = 32'h040;
  localparam int unsigned HOLD   = 16;
  localparam int unsigned TOTAL  = CPU_B + GFX_B + PROM_B;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rgn;
    int          cyc;
  } exp_t;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              usr_reset = 1'b0;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [1:0]        dn_rgn;
  logic              core_reset;
  logic              load_ok;
  logic              load_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_wr     = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;

  rom_download_ctrl #(
    .ADDR_W(ADDR_W), .CPU_BYTES(CPU_B), .GFX_BYTES(GFX_B),
    .PROM_BYTES(PROM_B), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .usr_reset(usr_reset), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .dn_rgn(dn_rgn), .core_reset(core_reset), .load_ok(load_ok), .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int ref_rgn(input int unsigned a);
    if (a < CPU_B) return 0;
    if (a < CPU_B + GFX_B) return 1;
    return 2;
  endfunction

  // Monitor: every dn_wr must match the oldest outstanding accepted byte.
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n && dn_wr) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected dn_wr", 32'(dn_wr), 32'd0);
      end else begin
        e = sb.pop_front();
        check("dn_addr", 32'(dn_addr), e.addr);
        check("dn_data", 32'(dn_data), e.data);
        check("dn_rgn", 32'(dn_rgn), e.rgn);
        check("dn_wr latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input int unsigned a, input logic [7:0] d, input bit drop_dl, input bit gap);
    exp_t e;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (drop_dl) begin
      ioctl_download = 1'b0;
      fall_cyc = cyc;
    end
    if (a < TOTAL) begin
      e.addr = a;
      e.data = 32'(d);
      e.rgn  = 32'(ref_rgn(a));
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
    if (gap && $urandom_range(3) == 0) repeat ($urandom_range(3, 1)) tick();
  endtask

  task automatic begin_download();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    fall_cyc = cyc;
    tick();
  endtask

  task automatic wait_core_low(input string name, input int exp_cyc);
    int got = -1;
    for (int i = 0; i < 4 * HOLD + 20 && got < 0; i++) begin
      @(negedge clk_sys);
      if (!core_reset) got = cyc;
    end
    check(name, 32'(got), 32'(exp_cyc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    bit seen_low;

    // Reset state
    repeat (3) tick();
    check("rst dn_wr", 32'(dn_wr), 32'd0);
    check("rst dn_addr", 32'(dn_addr), 32'd0);
    check("rst dn_data", 32'(dn_data), 32'd0);
    check("rst dn_rgn", 32'(dn_rgn), 32'd0);
    check("rst core_reset", 32'(core_reset), 32'd1);
    check("rst load_ok", 32'(load_ok), 32'd0);
    check("rst load_err", 32'(load_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: full in-order load
    n0 = n_wr;
    begin_download();
    for (int unsigned a = 0; a < TOTAL; a++) send(a, a[7:0], 1'b0, 1'b1);
    end_download();
    check("t1 load_ok", 32'(load_ok), 32'd1);
    check("t1 load_err", 32'(load_err), 32'd0);
    check("t1 dn_wr count", 32'(n_wr - n0), 32'(TOTAL));
    check("t1 core_reset in hold", 32'(core_reset), 32'd1);
    wait_core_low("t1 core_reset release cycle", fall_cyc + HOLD + 1);

    // 4: user reset in RUN, then restart mid-hold
    tick();
    check("t4 running", 32'(core_reset), 32'd0);
    usr_reset = 1'b1;
    tick();
    usr_reset = 1'b0;
    check("t4 core_reset next cycle", 32'(core_reset), 32'd1);
    repeat (5) tick();
    usr_reset = 1'b1;
    m = cyc;
    tick();
    usr_reset = 1'b0;
    wait_core_low("t4 restarted hold release", m + HOLD + 1);

    // 5: download wins over usr_reset; reload with random order, last byte on the fall
    tick();
    ioctl_download = 1'b1;
    usr_reset = 1'b1;
    tick();
    usr_reset = 1'b0;
    check("t5 load_ok cleared", 32'(load_ok), 32'd0);
    check("t5 core_reset", 32'(core_reset), 32'd1);
    for (int unsigned i = 0; i < TOTAL - 1; i++)
      send($urandom_range(TOTAL - 1), 8'($urandom), 1'b0, 1'b1);
    send($urandom_range(TOTAL - 1), 8'($urandom), 1'b1, 1'b0);
    check("t5 load_ok", 32'(load_ok), 32'd1);
    check("t5 load_err", 32'(load_err), 32'd0);
    wait_core_low("t5 core_reset release cycle", fall_cyc + HOLD + 1);

    // 2: short load
    tick();
    begin_download();
    for (int unsigned a = 0; a < TOTAL - 1; a++) send(a, 8'($urandom), 1'b0, 1'b1);
    end_download();
    check("t2 load_err", 32'(load_err), 32'd1);
    check("t2 load_ok", 32'(load_ok), 32'd0);
    seen_low = 1'b0;
    for (int i = 0; i < 10 * HOLD; i++) begin
      tick();
      if (!core_reset) seen_low = 1'b1;
    end
    check("t2 core_reset held in ERR", 32'(seen_low), 32'd0);

    // 3: full load plus one out-of-range byte
    begin_download();
    for (int unsigned a = 0; a < TOTAL; a++) send(a, 8'($urandom), 1'b0, 1'b1);
    send(TOTAL, 8'($urandom), 1'b0, 1'b0);
    check("t3 oob byte no dn_wr", 32'(dn_wr), 32'd0);
    end_download();
    check("t3 load_err", 32'(load_err), 32'd1);
    check("t3 load_ok", 32'(load_ok), 32'd0);
    check("t3 core_reset", 32'(core_reset), 32'd1);

    // 6: async reset mid-load, download still high at release
    begin_download();
    for (int unsigned a = 0; a < 100; a++) send(a, 8'($urandom), 1'b0, 1'b0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6 rst dn_wr", 32'(dn_wr), 32'd0);
    check("t6 rst dn_addr", 32'(dn_addr), 32'd0);
    check("t6 rst dn_rgn", 32'(dn_rgn), 32'd0);
    check("t6 rst core_reset", 32'(core_reset), 32'd1);
    check("t6 rst load_err", 32'(load_err), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    end_download();
    check("t6 load_err", 32'(load_err), 32'd1);
    check("t6 load_ok", 32'(load_ok), 32'd0);

    repeat (4) tick();
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
